ram_dump_ctrl: RTL and testbench

Autonomous controller for the 32x4 single-port synchronous RAM used in the Lab 7 memory datapath. It drives the RAM's address, data and write-enable in place of the switch-driven writer. On `start` it either clears the whole array to zero or reads every word out in address order over a valid/ready stream, for display or for a downstream checker. It sits between the RAM instance and any consumer of memory contents.

---
 rtl/ram_dump_ctrl_if.sv | 36 +++
 rtl/ram_dump_ctrl.sv | 174 +++++++++++++++++
 tb/tb_ram_dump_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_dump_ctrl_if.sv
// ram_dump_ctrl_if
//   Valid/ready stream that carries RAM words out of ram_dump_ctrl, one word
//   per handshake, tagged with the RAM address the word came from.
//
//   Signals:
//     out_valid    controller -> consumer  a word is presented
//     out_ready    consumer -> controller  the consumer takes the word this cycle
//     out_address  controller -> consumer  RAM address of the presented word
//     out_data     controller -> consumer  RAM word captured from that address
//
//   Modports:
//     master  the controller side (drives valid/address/data)
//     slave   the consumer side (drives ready)
interface ram_dump_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 4
);
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_address;
  logic [DATA_W-1:0] out_data;

  modport master (
    output out_valid,
    output out_address,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_address,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/ram_dump_ctrl.sv
// ram_dump_ctrl
//   Autonomous sweeper for a single-port synchronous RAM (address/data/wren
//   registered on the clock edge, q valid in the following cycle). On start it
//   either writes zero to every word (clear sweep) or reads every word in
//   ascending address order and offers it on a valid/ready stream (dump sweep).
//
//   Ports:
//     clock        single clock for this block and for the RAM
//     reset        synchronous active-high reset
//     start        begin a sweep; only looked at while idle
//     clear_mode   sampled with start: 1 = clear sweep, 0 = dump sweep
//     ram_address  RAM address (the sweep counter)
//     ram_data     RAM write data, constant zero
//     ram_wren     RAM write enable, high only while clearing
//     ram_q        RAM read data
//     dump         stream of dumped words (master side of ram_dump_ctrl_if)
//     busy         high whenever the controller is not idle
//     done         one-cycle pulse closing a completed sweep
//
//   Parameter DEPTH is the number of words swept, 1 <= DEPTH <= 2**ADDR_W.
module ram_dump_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 4,
  parameter int DEPTH  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              clear_mode,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  ram_dump_ctrl_if.master   dump,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_CLEAR,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  state_t            state_reg;
  state_t            state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] addr_next;
  logic [DATA_W-1:0] out_data_reg;
  logic [ADDR_W-1:0] out_address_reg;

  logic              at_last;
  logic              out_valid;
  logic              capture;
  logic              flush;

  // The sweep ends on the last address instead of wrapping, so address 0 is
  // never revisited within one sweep.
  assign at_last = (addr_reg == LAST_ADDR);

  // State and address counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= S_IDLE;
      addr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
    end
  end

  // Next-state and decoded outputs.
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    ram_wren   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    capture    = 1'b0;
    flush      = 1'b0;

    case (state_reg)
      S_IDLE: begin
        busy      = 1'b0;
        addr_next = '0;
        if (start) begin
          state_next = clear_mode ? S_CLEAR : S_ISSUE;
        end
      end

      // One zero write per address; the RAM registers the write on the edge
      // that ends this cycle.
      S_CLEAR: begin
        ram_wren = 1'b1;
        if (at_last) begin
          state_next = S_DONE;
        end else begin
          addr_next = addr_reg + ADDR_ONE;
        end
      end

      // Address is presented to the RAM; it is registered at the end of this
      // cycle.
      S_ISSUE: begin
        state_next = S_WAIT;
      end

      // RAM q now reflects the registered address; grab it at the edge.
      S_WAIT: begin
        capture    = 1'b1;
        state_next = S_HOLD;
      end

      // The captured word is held until the consumer takes it. The address
      // stays parked so the RAM keeps reading the same location.
      S_HOLD: begin
        out_valid = 1'b1;
        if (dump.out_ready) begin
          if (at_last) begin
            state_next = S_DONE;
          end else begin
            addr_next  = addr_reg + ADDR_ONE;
            state_next = S_ISSUE;
          end
        end
      end

      // Completion pulse; the stream registers are zeroed so the idle
      // controller presents all-low outputs.
      S_DONE: begin
        done       = 1'b1;
        flush      = 1'b1;
        addr_next  = '0;
        state_next = S_IDLE;
      end

      default: begin
        busy       = 1'b0;
        addr_next  = '0;
        state_next = S_IDLE;
      end
    endcase
  end

  // Captured word and its address. A reset discards any word in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_data_reg    <= '0;
      out_address_reg <= '0;
    end else if (capture) begin
      out_data_reg    <= ram_q;
      out_address_reg <= addr_reg;
    end else if (flush) begin
      out_data_reg    <= '0;
      out_address_reg <= '0;
    end
  end

  // The counter itself addresses the RAM; it is zero while idle.
  assign ram_address      = addr_reg;
  assign ram_data         = '0;

  assign dump.out_valid   = out_valid;
  assign dump.out_data    = out_data_reg;
  assign dump.out_address = out_address_reg;

endmodule

// File: tb/tb_ram_dump_ctrl.sv
module tb_ram_dump_ctrl;

  localparam int AW = 5;
  localparam int DW = 4;
  localparam int N  = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          clear_mode = 1'b0;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data;
  logic          ram_wren;
  logic [DW-1:0] ram_q;
  logic          busy;
  logic          done;

  ram_dump_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) dump_if ();

  ram_dump_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(N)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .clear_mode  (clear_mode),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_wren    (ram_wren),
    .ram_q       (ram_q),
    .dump        (dump_if),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;

  // Behavioural single-port RAM with registered inputs plus a bench-only
  // preload port used while the controller is idle.
  logic [DW-1:0] mem [N];
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  always @(posedge clock) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (ram_wren) mem[ram_address] <= ram_data;
    ram_q <= mem[ram_address];
  end

  // Reference contents the RAM is expected to hold.
  logic [DW-1:0] model_mem [N];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            t;
  } hs_t;

  hs_t hs_q[$];
  int  wren_cnt;
  int  done_cnt;
  int  stall_cnt;
  int  bad_data_cnt;
  bit  busy_at_done;
  bit  busy_first;
  logic [DW-1:0] snap_data[$];
  logic [AW-1:0] snap_addr[$];
  logic [AW-1:0] snap_raddr[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Observation away from the active edge.
  always @(negedge clock) begin
    if (dump_if.out_valid && dump_if.out_ready) begin
      hs_q.push_back('{a: dump_if.out_address, d: dump_if.out_data, t: cyc});
      $display("word addr=%0d data=%h cycle=%0d", dump_if.out_address, dump_if.out_data, cyc);
    end
    if (dump_if.out_valid && !dump_if.out_ready) stall_cnt++;
    if (ram_wren) wren_cnt++;
    if (done) done_cnt++;
    if (ram_data !== '0) bad_data_cnt++;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_counters();
    hs_q.delete();
    snap_data.delete();
    snap_addr.delete();
    snap_raddr.delete();
    wren_cnt     = 0;
    done_cnt     = 0;
    stall_cnt    = 0;
    bad_data_cnt = 0;
  endtask

  // kind: 0 = a[3:0], 1 = (3a)&F, 2 = 4'hA, 3 = random
  task automatic preload(input int kind);
    logic [DW-1:0] v;
    for (int a = 0; a < N; a++) begin
      case (kind)
        0:       v = a[3:0];
        1:       v = 4'((a * 3) & 15);
        2:       v = 4'hA;
        default: v = 4'($urandom_range(0, 15));
      endcase
      model_mem[a] = v;
      pre_en   = 1'b1;
      pre_addr = 5'(a);
      pre_data = v;
      step();
    end
    pre_en = 1'b0;
    step();
  endtask

  // Runs one sweep. cycles = index of the done cycle counted from the cycle
  // after start is sampled (1-based), or -1 if done never appeared.
  task automatic sweep(input bit clr, input int stall_addr, input int stall_len,
                       input bit rnd_ready, input int inject_at,
                       output int cycles, output int e0);
    int stalls;
    stalls = 0;
    clear_counters();
    dump_if.out_ready = 1'b1;
    start      = 1'b1;
    clear_mode = clr;
    step();
    e0         = cyc;
    start      = 1'b0;
    clear_mode = 1'b0;
    busy_first = busy;
    cycles     = 1;
    while (!done && cycles < 2000) begin
      if (rnd_ready) begin
        dump_if.out_ready = ($urandom_range(0, 3) != 0);
      end else if (stall_addr >= 0 && dump_if.out_valid &&
                   dump_if.out_address == stall_addr && stalls < stall_len) begin
        dump_if.out_ready = 1'b0;
        stalls++;
        snap_data.push_back(dump_if.out_data);
        snap_addr.push_back(dump_if.out_address);
        snap_raddr.push_back(ram_address);
      end else begin
        dump_if.out_ready = 1'b1;
      end
      if (cycles == inject_at) begin
        start      = 1'b1;
        clear_mode = 1'b1;
      end else begin
        start      = 1'b0;
        clear_mode = 1'b0;
      end
      step();
      cycles++;
    end
    start      = 1'b0;
    clear_mode = 1'b0;
    dump_if.out_ready = 1'b1;
    if (!done) cycles = -1;
    busy_at_done = busy;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    clear_mode = 1'b0;
    dump_if.out_ready = 1'b1;
    step();
    step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b want=0", done); end
    n_checks++; if (ram_wren !== 1'b0) begin n_fail++; $display("FAIL reset_wren got=%b want=0", ram_wren); end
    n_checks++; if (ram_address !== 5'd0) begin n_fail++; $display("FAIL reset_ram_address got=%0d want=0", ram_address); end
    n_checks++; if (ram_data !== 4'd0) begin n_fail++; $display("FAIL reset_ram_data got=%h want=0", ram_data); end
    n_checks++; if (dump_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", dump_if.out_valid); end
    n_checks++; if (dump_if.out_data !== 4'd0) begin n_fail++; $display("FAIL reset_out_data got=%h want=0", dump_if.out_data); end
    n_checks++; if (dump_if.out_address !== 5'd0) begin n_fail++; $display("FAIL reset_out_address got=%0d want=0", dump_if.out_address); end
    reset = 1'b0;
    start = 1'b0;
    clear_counters();
    repeat (5) step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_no_start_busy got=%b want=0", busy); end
    n_checks++; if (wren_cnt !== 0) begin n_fail++; $display("FAIL reset_no_start_wren got=%0d want=0", wren_cnt); end
  endtask

  task automatic test_clear_then_dump();
    int c;
    int e0;
    preload(0);
    sweep(1'b1, -1, 0, 1'b0, -1, c, e0);
    for (int a = 0; a < N; a++) model_mem[a] = '0;
    n_checks++; if (c !== N + 1) begin n_fail++; $display("FAIL clear_cycles got=%0d want=%0d", c, N + 1); end
    n_checks++; if (wren_cnt !== N) begin n_fail++; $display("FAIL clear_wren_count got=%0d want=%0d", wren_cnt, N); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL clear_done_count got=%0d want=1", done_cnt); end
    n_checks++; if (busy_first !== 1'b1) begin n_fail++; $display("FAIL clear_busy_rise got=%b want=1", busy_first); end
    n_checks++; if (busy_at_done !== 1'b1) begin n_fail++; $display("FAIL clear_busy_at_done got=%b want=1", busy_at_done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clear_busy_after got=%b want=0", busy); end
    n_checks++; if (bad_data_cnt !== 0) begin n_fail++; $display("FAIL clear_nonzero_data got=%0d want=0", bad_data_cnt); end
    for (int a = 0; a < N; a++) begin
      n_checks++; if (mem[a] !== model_mem[a]) begin n_fail++; $display("FAIL clear_mem[%0d] got=%h want=%h", a, mem[a], model_mem[a]); end
    end
    // Start issued in the first idle cycle after done.
    sweep(1'b0, -1, 0, 1'b0, -1, c, e0);
    n_checks++; if (c !== 3 * N + 1) begin n_fail++; $display("FAIL b2b_dump_cycles got=%0d want=%0d", c, 3 * N + 1); end
    n_checks++; if (hs_q.size() !== N) begin n_fail++; $display("FAIL b2b_dump_words got=%0d want=%0d", hs_q.size(), N); end
    for (int k = 0; k < hs_q.size() && k < N; k++) begin
      n_checks++; if (hs_q[k].a !== 5'(k) || hs_q[k].d !== 4'd0) begin n_fail++; $display("FAIL b2b_word[%0d] got=%0d/%h want=%0d/0", k, hs_q[k].a, hs_q[k].d, k); end
    end
  endtask

  task automatic test_dump_pattern();
    int c;
    int e0;
    preload(1);
    sweep(1'b0, -1, 0, 1'b0, -1, c, e0);
    n_checks++; if (c !== 3 * N + 1) begin n_fail++; $display("FAIL pattern_cycles got=%0d want=%0d", c, 3 * N + 1); end
    n_checks++; if (hs_q.size() !== N) begin n_fail++; $display("FAIL pattern_words got=%0d want=%0d", hs_q.size(), N); end
    n_checks++; if (wren_cnt !== 0) begin n_fail++; $display("FAIL pattern_wren got=%0d want=0", wren_cnt); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL pattern_done_count got=%0d want=1", done_cnt); end
    if (hs_q.size() > 0) begin
      n_checks++; if (hs_q[0].t !== e0 + 2) begin n_fail++; $display("FAIL pattern_first_valid got=%0d want=%0d", hs_q[0].t, e0 + 2); end
    end
    for (int k = 0; k < hs_q.size() && k < N; k++) begin
      n_checks++; if (hs_q[k].a !== 5'(k) || hs_q[k].d !== 4'((3 * k) & 15)) begin n_fail++; $display("FAIL pattern_word[%0d] got=%0d/%h want=%0d/%h", k, hs_q[k].a, hs_q[k].d, k, 4'((3 * k) & 15)); end
      if (k > 0) begin
        n_checks++; if (hs_q[k].t - hs_q[k-1].t !== 3) begin n_fail++; $display("FAIL pattern_spacing[%0d] got=%0d want=3", k, hs_q[k].t - hs_q[k-1].t); end
      end
    end
    n_checks++; if (dump_if.out_valid !== 1'b0 || dump_if.out_data !== 4'd0) begin n_fail++; $display("FAIL pattern_idle_out got=%b/%h want=0/0", dump_if.out_valid, dump_if.out_data); end
  endtask

  task automatic test_back_pressure();
    int c;
    int e0;
    preload(3);
    sweep(1'b0, 7, 5, 1'b0, -1, c, e0);
    n_checks++; if (c !== 3 * N + 1 + 5) begin n_fail++; $display("FAIL bp_cycles got=%0d want=%0d", c, 3 * N + 6); end
    n_checks++; if (snap_data.size() !== 5) begin n_fail++; $display("FAIL bp_stall_count got=%0d want=5", snap_data.size()); end
    for (int i = 0; i < snap_data.size(); i++) begin
      n_checks++; if (snap_data[i] !== model_mem[7] || snap_addr[i] !== 5'd7 || snap_raddr[i] !== 5'd7) begin n_fail++; $display("FAIL bp_hold[%0d] got=%h/%0d/%0d want=%h/7/7", i, snap_data[i], snap_addr[i], snap_raddr[i], model_mem[7]); end
    end
    n_checks++; if (hs_q.size() !== N) begin n_fail++; $display("FAIL bp_words got=%0d want=%0d", hs_q.size(), N); end
    for (int k = 0; k < hs_q.size() && k < N; k++) begin
      n_checks++; if (hs_q[k].a !== 5'(k) || hs_q[k].d !== model_mem[k]) begin n_fail++; $display("FAIL bp_word[%0d] got=%0d/%h want=%0d/%h", k, hs_q[k].a, hs_q[k].d, k, model_mem[k]); end
    end
  endtask

  task automatic test_start_ignored();
    int c;
    int e0;
    preload(3);
    sweep(1'b0, -1, 0, 1'b0, 40, c, e0);
    n_checks++; if (c !== 3 * N + 1) begin n_fail++; $display("FAIL ignore_cycles got=%0d want=%0d", c, 3 * N + 1); end
    n_checks++; if (wren_cnt !== 0) begin n_fail++; $display("FAIL ignore_wren got=%0d want=0", wren_cnt); end
    n_checks++; if (hs_q.size() !== N) begin n_fail++; $display("FAIL ignore_words got=%0d want=%0d", hs_q.size(), N); end
    for (int k = 0; k < hs_q.size() && k < N; k++) begin
      n_checks++; if (hs_q[k].a !== 5'(k) || hs_q[k].d !== model_mem[k]) begin n_fail++; $display("FAIL ignore_word[%0d] got=%0d/%h want=%0d/%h", k, hs_q[k].a, hs_q[k].d, k, model_mem[k]); end
    end
    repeat (3) step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_no_queue got=%b want=0", busy); end
    for (int a = 0; a < N; a++) begin
      n_checks++; if (mem[a] !== model_mem[a]) begin n_fail++; $display("FAIL ignore_mem[%0d] got=%h want=%h", a, mem[a], model_mem[a]); end
    end
  endtask

  task automatic test_random_ready();
    int c;
    int e0;
    preload(3);
    sweep(1'b0, -1, 0, 1'b1, -1, c, e0);
    n_checks++; if (c !== 3 * N + 1 + stall_cnt) begin n_fail++; $display("FAIL rnd_cycles got=%0d want=%0d", c, 3 * N + 1 + stall_cnt); end
    n_checks++; if (hs_q.size() !== N) begin n_fail++; $display("FAIL rnd_words got=%0d want=%0d", hs_q.size(), N); end
    for (int k = 0; k < hs_q.size() && k < N; k++) begin
      n_checks++; if (hs_q[k].a !== 5'(k) || hs_q[k].d !== model_mem[k]) begin n_fail++; $display("FAIL rnd_word[%0d] got=%0d/%h want=%0d/%h", k, hs_q[k].a, hs_q[k].d, k, model_mem[k]); end
    end
  endtask

  task automatic test_reset_during_clear();
    int n;
    preload(2);
    clear_counters();
    start      = 1'b1;
    clear_mode = 1'b1;
    step();
    start      = 1'b0;
    clear_mode = 1'b0;
    n = 0;
    while (!(ram_wren === 1'b1 && ram_address === 5'd10) && n < 64) begin
      step();
      n++;
    end
    n_checks++; if (n >= 64) begin n_fail++; $display("FAIL rst_clear_reach got=timeout want=address 10"); end
    reset = 1'b1;
    step();
    n_checks++; if (ram_wren !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_clear_stop got=%b/%b want=0/0", ram_wren, busy); end
    reset = 1'b0;
    repeat (40) step();
    for (int a = 0; a <= 10; a++) model_mem[a] = '0;
    n_checks++; if (done_cnt !== 0) begin n_fail++; $display("FAIL rst_clear_done got=%0d want=0", done_cnt); end
    n_checks++; if (wren_cnt !== 11) begin n_fail++; $display("FAIL rst_clear_writes got=%0d want=11", wren_cnt); end
    for (int a = 0; a < N; a++) begin
      n_checks++; if (mem[a] !== model_mem[a]) begin n_fail++; $display("FAIL rst_clear_mem[%0d] got=%h want=%h", a, mem[a], model_mem[a]); end
    end
  endtask

  initial begin
    dump_if.out_ready = 1'b1;
    test_reset();
    test_clear_then_dump();
    test_dump_pattern();
    test_back_pressure();
    test_start_ignored();
    test_random_ready();
    test_reset_during_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
